// File: rtl/key_pulse_gen.sv
// -----------------------------------------------------------------------------
// key_pulse_gen
//
// Front-end conditioner for the five panel push-buttons.  Each raw button is
// optionally inverted, passed through a two-flop synchronizer, debounced with
// a stable-sample counter and edge-detected.  Press candidates are arbitrated
// by fixed priority (restart > left > right > up > down).  A two-state lockout
// FSM lets through at most one direction pulse per press episode; restart is
// exempt from the lockout and forces the FSM back to IDLE.
//
// Parameters:
//   DB_CYCLES  : consecutive stable synced samples needed to accept a change (>= 2)
//   CNT_W      : debounce counter width, 2**CNT_W > DB_CYCLES
//   ACTIVE_LOW : 1 = raw key reads 0 when pressed
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_in[4:0]  in   raw buttons: [0] restart [1] left [2] right [3] up [4] down
//   RESTARTdown  out  one-cycle pulse on accepted restart press
//   LeftDown     out  one-cycle pulse on accepted left press
//   RightDown    out  one-cycle pulse on accepted right press
//   UpDown       out  one-cycle pulse on accepted up press
//   DownDown     out  one-cycle pulse on accepted down press
//   key_level    out  debounced pressed level per key (1 = pressed)
//   busy         out  1 while the lockout FSM holds a direction press
// -----------------------------------------------------------------------------
module key_pulse_gen #(
   parameter int DB_CYCLES  = 20000,
   parameter int CNT_W      = 15,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key_in,
   output logic       RESTARTdown,
   output logic       LeftDown,
   output logic       RightDown,
   output logic       UpDown,
   output logic       DownDown,
   output logic [4:0] key_level,
   output logic       busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   // Counter value at which the next differing sample flips the debounced level.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [4:0]       pressed_s;
   logic [4:0]       sync1_r;
   logic [4:0]       sync2_r;
   logic [4:0]       deb_r;
   logic [4:0]       deb_prev_r;
   logic [CNT_W-1:0] cnt_r [5];
   logic [4:0]       cand_s;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [4:0]       pulse_nxt_s;
   logic [4:0]       pulse_r;

   // Highest-priority direction candidate as a one-hot vector (bit 0 ignored).
   function automatic logic [4:0] first_dir(input logic [4:0] c);
      logic [4:0] r;
      r = 5'b00000;
      if (c[1]) begin
         r = 5'b00010;
      end else if (c[2]) begin
         r = 5'b00100;
      end else if (c[3]) begin
         r = 5'b01000;
      end else if (c[4]) begin
         r = 5'b10000;
      end else begin
         r = 5'b00000;
      end
      return r;
   endfunction

   // Normalise polarity so that 1 always means pressed internally.
   always_comb begin
      pressed_s = key_in;
      if (ACTIVE_LOW) begin
         pressed_s = ~key_in;
      end else begin
         pressed_s = key_in;
      end
   end

   // Two-flop synchronizer; resets to released so reset release never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 5'b00000;
         sync2_r <= 5'b00000;
      end else begin
         sync1_r <= pressed_s;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: count consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin
            cnt_r[i] <= '0;
         end
         deb_r <= 5'b00000;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (cnt_r[i] == DB_LAST) begin
                  deb_r[i] <= ~deb_r[i];
                  cnt_r[i] <= '0;
               end else begin
                  cnt_r[i] <= cnt_r[i] + CNT_W'(1);
               end
            end else begin
               cnt_r[i] <= '0;
            end
         end
      end
   end

   // Previous debounced level for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_prev_r <= 5'b00000;
      end else begin
         deb_prev_r <= deb_r;
      end
   end

   assign cand_s = deb_r & ~deb_prev_r;

   // Lockout FSM next state and pulse selection; losing candidates are dropped.
   always_comb begin
      state_nxt_s = state_r;
      pulse_nxt_s = 5'b00000;
      if (cand_s[0]) begin
         // Restart wins over everything and clears any lockout.
         pulse_nxt_s = 5'b00001;
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|cand_s[4:1]) begin
                  pulse_nxt_s = first_dir(cand_s);
                  state_nxt_s = ST_HELD;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (deb_r[4:1] == 4'b0000) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_HELD;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state and registered pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         pulse_r <= 5'b00000;
      end else begin
         state_r <= state_nxt_s;
         pulse_r <= pulse_nxt_s;
      end
   end

   assign RESTARTdown = pulse_r[0];
   assign LeftDown    = pulse_r[1];
   assign RightDown   = pulse_r[2];
   assign UpDown      = pulse_r[3];
   assign DownDown    = pulse_r[4];
   assign key_level   = deb_r;
   assign busy        = (state_r == ST_HELD);

endmodule

// File: tb/tb_key_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_gen
//
// Two instances with DB_CYCLES=4: one active-high, one active-low fed the
// inverted key vector, so both must behave identically.  A behavioural model
// (raw-sample delay line, sliding window of synced samples, priority/lockout
// rules) predicts the outputs; they are compared on every falling edge.  A few
// literal checks pin the press latency and the asynchronous reset.
// -----------------------------------------------------------------------------
module tb_key_pulse_gen;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] key_in = 5'b00000;
   logic [4:0] key_in_n;

   logic       rs_a, lf_a, rt_a, up_a, dn_a, busy_a;
   logic [4:0] lvl_a;
   logic       rs_b, lf_b, rt_b, up_b, dn_b, busy_b;
   logic [4:0] lvl_b;

   int n_cmp = 0;
   int n_bad = 0;

   assign key_in_n = ~key_in;

   key_pulse_gen #(.DB_CYCLES(DB), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .key_in(key_in),
      .RESTARTdown(rs_a), .LeftDown(lf_a), .RightDown(rt_a), .UpDown(up_a),
      .DownDown(dn_a), .key_level(lvl_a), .busy(busy_a));

   key_pulse_gen #(.DB_CYCLES(DB), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .key_in(key_in_n),
      .RESTARTdown(rs_b), .LeftDown(lf_b), .RightDown(rt_b), .UpDown(up_b),
      .DownDown(dn_b), .key_level(lvl_b), .busy(busy_b));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [4:0] raw_q [$];
   logic [4:0] win_q [$];
   logic [4:0] m_lvl   = 5'b00000;
   logic [4:0] m_prev  = 5'b00000;
   logic [4:0] m_pulse = 5'b00000;
   bit         m_held  = 1'b0;
   logic [4:0] m_s, m_cand;
   bit         m_all, m_found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_q.delete();
         win_q.delete();
         m_lvl   = 5'b00000;
         m_prev  = 5'b00000;
         m_pulse = 5'b00000;
         m_held  = 1'b0;
      end else begin
         // The synced sample judged at this edge is the raw key two edges back.
         m_s = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 5'b00000;
         m_cand  = m_lvl & ~m_prev;
         m_pulse = 5'b00000;
         if (m_cand[0]) begin
            m_pulse = 5'b00001;
            m_held  = 1'b0;
         end else if (!m_held && (m_cand[4:1] != 4'b0000)) begin
            m_found = 1'b0;
            for (int k = 1; k < 5; k++) begin
               if (m_cand[k] && !m_found) begin
                  m_pulse[k] = 1'b1;
                  m_found    = 1'b1;
               end
            end
            m_held = 1'b1;
         end else if (m_held && (m_lvl[4:1] == 4'b0000)) begin
            m_held = 1'b0;
         end
         m_prev = m_lvl;
         // Level flips once the last DB synced samples all disagree with it.
         win_q.push_back(m_s);
         if (win_q.size() > DB) void'(win_q.pop_front());
         if (win_q.size() == DB) begin
            for (int k = 0; k < 5; k++) begin
               m_all = 1'b1;
               for (int j = 0; j < DB; j++) begin
                  if (win_q[j][k] == m_lvl[k]) m_all = 1'b0;
               end
               if (m_all) m_lvl[k] = ~m_lvl[k];
            end
         end
         raw_q.push_back(key_in);
         if (raw_q.size() > 4) void'(raw_q.pop_front());
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("dut_a_outputs", {21'd0, dn_a, up_a, rt_a, lf_a, rs_a, lvl_a, busy_a},
          {21'd0, m_pulse, m_lvl, m_held});
      chk("dut_b_outputs", {21'd0, dn_b, up_b, rt_b, lf_b, rs_b, lvl_b, busy_b},
          {21'd0, m_pulse, m_lvl, m_held});
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_a"}, {20'd0, rs_a, lf_a, rt_a, up_a, dn_a, lvl_a, busy_a}, 32'd0);
      chk({nm, "_b"}, {20'd0, rs_b, lf_b, rt_b, up_b, dn_b, lvl_b, busy_b}, 32'd0);
   endtask

   int r;
   int idx;

   initial begin
      rst_n  = 1'b0;
      key_in = 5'b00000;
      hold(3);
      rst_n = 1'b1;
      // Both instances idle through reset release (dut_b sees all keys high).
      hold(50);
      chk_all_zero("idle_after_reset");

      // Clean left press: literal latency checks.
      key_in = 5'b00010;
      repeat (5) @(posedge clk);
      #1 chk("left_level_edge4", {31'd0, lvl_a[1]}, 32'd0);
      @(posedge clk);
      #1 chk("left_level_edge5", {31'd0, lvl_a[1]}, 32'd1);
      chk("left_pulse_edge5", {31'd0, lf_a}, 32'd0);
      @(posedge clk);
      #1 chk("left_pulse_edge6", {31'd0, lf_a}, 32'd1);
      chk("busy_edge6", {31'd0, busy_a}, 32'd1);
      @(posedge clk);
      #1 chk("left_pulse_edge7", {31'd0, lf_a}, 32'd0);
      hold(12);
      key_in = 5'b00000;
      hold(10);
      chk("busy_after_release", {31'd0, busy_a}, 32'd0);

      // Bouncing up key, then steady; then a too-short press.
      for (int i = 0; i < 4; i++) begin
         key_in = (i % 2 == 0) ? 5'b01000 : 5'b00000;
         hold(1);
      end
      key_in = 5'b01000; hold(12);
      key_in = 5'b00000; hold(10);
      key_in = 5'b01000; hold(3);
      key_in = 5'b00000; hold(10);

      // Left and down together, then release order.
      key_in = 5'b10010; hold(10);
      key_in = 5'b10000; hold(10);
      key_in = 5'b00000; hold(10);
      key_in = 5'b10000; hold(10);
      key_in = 5'b00000; hold(10);

      // Right held, up ignored, restart breaks the lock.
      key_in = 5'b00100; hold(10);
      key_in = 5'b01100; hold(10);
      key_in = 5'b01101; hold(10);
      key_in = 5'b00000; hold(10);

      // Asynchronous reset during HELD.
      key_in = 5'b00010; hold(8);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      hold(12);
      key_in = 5'b00000; hold(10);

      // Asynchronous reset mid-debounce, key held across release.
      key_in = 5'b00100; hold(4);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst_debounce");
      @(negedge clk);
      rst_n = 1'b1;
      hold(12);
      key_in = 5'b00000; hold(10);

      // Randomized stimulus with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         if (r < 12) begin
            idx = $urandom_range(0, 4);
            key_in[idx] = ~key_in[idx];
         end else if (r < 14) begin
            key_in = 5'($urandom_range(0, 31));
         end
         #2;
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
      end
      rst_n = 1'b1;
      key_in = 5'b00000;
      hold(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Front-end key conditioner for the vision-test panel: synchronizes and debounces the five raw push-buttons (restart, left, right, up, down) and converts each press into a single-clock pulse on `RESTARTdown`/`LeftDown`/`RightDown`/`UpDown`/`DownDown`, the signals consumed by the state/display controller. A one-key-at-a-time lockout FSM ensures at most one direction pulse per physical press episode, so a single answer is scored once even if keys chatter or overlap.

## Interface
- `DB_CYCLES`, 20000: consecutive stable samples required to accept a level change (20 ms at 1 MHz); legal range ≥ 2.
- `CNT_W`, 15: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
- `ACTIVE_LOW`, 0: 1 = raw key reads 0 when pressed; inverted at input so internal logic is always 1 = pressed.
- `clk`  in  1  system clock, sole clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  5  raw asynchronous buttons: [0] restart, [1] left, [2] right, [3] up, [4] down.
- `RESTARTdown`  out  1  one-cycle pulse on accepted restart press.
- `LeftDown`, `RightDown`, `UpDown`, `DownDown`  out  1 each  one-cycle pulse on accepted direction press.
- `key_level`  out  5  debounced pressed level per key (1 = pressed).
- `busy`  out  1  1 while lockout FSM is in HELD.

## Operation
- Per key: 2-FF synchronizer (after optional inversion) -> debounce counter -> debounced level register -> rising-edge detect.
- Debounce: if synced ≠ debounced, counter increments; if equal, counter clears to 0. When counter == DB_CYCLES-1 and still differing, debounced level toggles and counter clears the same edge. Any single mismatching-then-matching glitch restarts the count. Releases debounce identically.
- Rising edge of any debounced level = press candidate. Candidates same cycle arbitrated by fixed priority restart > left > right > up > down; only the winner pulses, losers are discarded (never delayed/queued; re-arm only after release and re-press).
- Lockout FSM, two states:
  - IDLE: a direction candidate wins -> emit its pulse, go HELD. No candidates -> stay.
  - HELD: all direction candidates ignored. Exit to IDLE when `key_level[4:1]` == 0 for one sampled cycle.
- Restart exempt from lockout: restart candidate pulses in either state, takes priority over any simultaneous direction candidate, and forces FSM to IDLE.
- Outputs are registered; at most one of the five pulse outputs high in any cycle.

## Timing
- Reset (rst_n low, async): synchronizers and debounced levels = released (0 internal), counters = 0, FSM = IDLE, all pulses = 0, `key_level` = 0, `busy` = 0. No pulse may be generated by reset release itself, for either ACTIVE_LOW setting.
- Press latency: raw level stable before edge 0 -> sync2 valid after edge 1 -> debounced toggles at edge DB_CYCLES+1 (`key_level` high from then) -> pulse high for exactly the cycle after edge DB_CYCLES+2.
- `busy` rises the same edge the direction pulse is asserted; falls the edge after `key_level[4:1]` first reads all-zero.
- Press shorter than DB_CYCLES synced cycles: no level change, no pulse.
- Holding a key indefinitely: one pulse only; counter stays 0.
- Reset asserted mid-debounce or mid-HELD: immediate return to reset values; a key still held at reset release re-debounces and pulses once (debounced starts released).

## Test plan
- DB_CYCLES=4, clean left press held 20 cycles: `LeftDown` high exactly one cycle, 6 cycles after first sampling edge; `key_level[1]`=1 from edge 5; `busy`=1 until release debounces.
- DB_CYCLES=4, up key bouncing 1,0,1,0 every cycle then steady 1: exactly one `UpDown` pulse, issued 6 cycles after final steady start; 3-cycle press alone -> no pulse.
- Left and down debounced same cycle: only `LeftDown` pulses; down then held and left released -> no `DownDown` until down released and re-pressed after `busy` falls.
- While right held (HELD), press up: no `UpDown`; press restart: `RESTARTdown` pulses once, `busy` drops to 0.
- ACTIVE_LOW=1, key_in=5'b11111 through reset release for 50 cycles: all outputs stay 0; drive bit 3 low -> single `UpDown` pulse.
- Assert rst_n low mid-debounce (count=2) and during HELD: all outputs 0 within same cycle (async); key held across release -> exactly one pulse DB_CYCLES+3 cycles later.
